// File: rtl/seg_capture_pkg.sv
// Shared definitions for the seven-segment capture block: glyph table,
// FSM state encoding and digit-enable helpers.
package seg_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } cap_state_e;

  localparam int NUM_DIGITS = 4;

  // Index i holds the segment pattern (g..a, active-high) the display decoder
  // drives for hex value i.
  localparam logic [6:0] SEG_GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic an_active(input logic [3:0] an);
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    case (an)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_capture_encode.sv
// Combinational seven-segment pattern to hex nibble lookup.
module seg_encode
  import seg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       legal
);

  always_comb begin
    value = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_GLYPHS[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Recovers hex digits from a multiplexed seven-segment display bus by waiting
// for each digit's pattern to stay stable, then assembling a four-digit frame.
module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  SEG_IN,
  input  logic [3:0]  AN_IN,
  output logic [15:0] DIGITS_OUT,
  output logic [3:0]  SEEN_OUT,
  output logic        FRAME_VALID,
  output logic        ERR_OUT
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  // The decimal-point bit carries no digit information.
  logic unused_seg_msb;
  assign unused_seg_msb = SEG_IN[7];

  logic [3:0]  an_q, an_d, prev_an_q, prev_an_d;
  logic [6:0]  seg_q, seg_d, prev_seg_q, prev_seg_d;
  cap_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;

  logic        active, same, capture;
  logic [1:0]  idx;
  logic [7:0]  cnt_inc;
  logic [3:0]  enc_value;
  logic        enc_legal;

  seg_encode u_encode (
    .pattern (seg_q),
    .value   (enc_value),
    .legal   (enc_legal)
  );

  always_comb begin
    an_d       = AN_IN;
    seg_d      = SEG_IN[6:0];
    prev_an_d  = an_q;
    prev_seg_d = seg_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    seen_d     = frame_q ? 4'b0000 : seen_q;
    frame_d    = 1'b0;
    err_d      = 1'b0;
    capture    = 1'b0;

    active  = an_active(an_q);
    same    = (an_q == prev_an_q) && (seg_q == prev_seg_q);
    idx     = an_index(an_q);
    cnt_inc = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d = cnt_inc;
          // Decide on the edge that completes the window so the nibble is
          // visible one edge later, not two.
          if (cnt_inc == STABLE_CNT) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end else begin
          cnt_d = 8'd1;
        end
      end
      HELD: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (capture) begin
      if (enc_legal) begin
        digits_d[idx*4 +: 4] = enc_value;
        seen_d[idx]          = 1'b1;
        frame_d              = (seen_d == 4'b1111);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      an_q       <= 4'b1111;
      seg_q      <= '0;
      prev_an_q  <= 4'b1111;
      prev_seg_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      digits_q   <= '0;
      seen_q     <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      an_q       <= an_d;
      seg_q      <= seg_d;
      prev_an_q  <= prev_an_d;
      prev_seg_q <= prev_seg_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      seen_q     <= seen_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign DIGITS_OUT  = digits_q;
  assign SEEN_OUT    = seen_q;
  assign FRAME_VALID = frame_q;
  assign ERR_OUT     = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scenarios plus randomized
// bursts, all compared against a run-length reference model.
module tb_seg_capture;

  localparam int S = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  SEG_IN;
  logic [3:0]  AN_IN;
  logic [15:0] DIGITS_OUT;
  logic [3:0]  SEEN_OUT;
  logic        FRAME_VALID;
  logic        ERR_OUT;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SEG_IN      (SEG_IN),
    .AN_IN       (AN_IN),
    .DIGITS_OUT  (DIGITS_OUT),
    .SEEN_OUT    (SEEN_OUT),
    .FRAME_VALID (FRAME_VALID),
    .ERR_OUT     (ERR_OUT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h58, 8'h5E, 8'h79, 8'h71
  };

  // Reference model state: registered sample, the one before it, and how many
  // consecutive identical active samples the capture logic has seen.
  logic [3:0]  m_cur_an, m_prev_an;
  logic [6:0]  m_cur_seg, m_prev_seg;
  int          run;
  logic [15:0] m_digits;
  logic [3:0]  m_seen;
  logic        m_frame, m_err;

  function automatic bit is_active(logic [3:0] an);
    return $countones(~an) == 1;
  endfunction

  function automatic int glyph_value(logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (GLYPH[i][6:0] == p) return i;
    return -1;
  endfunction

  task automatic tick(input logic [3:0] an, input logic [7:0] seg, input logic rst);
    int v;
    int di;
    AN_IN  = an;
    SEG_IN = seg;
    RESET  = rst;
    @(posedge CLK);
    if (rst) begin
      m_cur_an = 4'hF; m_prev_an = 4'hF; m_cur_seg = '0; m_prev_seg = '0;
      run = 0; m_digits = '0; m_seen = '0; m_frame = 0; m_err = 0;
    end else begin
      if (is_active(m_cur_an))
        run = (m_cur_an == m_prev_an && m_cur_seg == m_prev_seg) ? run + 1 : 1;
      else
        run = 0;
      if (m_frame) m_seen = '0;
      m_frame = 0;
      m_err   = 0;
      if (run == S) begin
        v  = glyph_value(m_cur_seg);
        di = 0;
        for (int i = 0; i < 4; i++) if (!m_cur_an[i]) di = i;
        if (v >= 0) begin
          m_digits[di*4 +: 4] = v[3:0];
          m_seen[di] = 1'b1;
          if (m_seen == 4'hF) m_frame = 1;
        end else begin
          m_err = 1;
        end
      end
      m_prev_an = m_cur_an; m_prev_seg = m_cur_seg;
      m_cur_an = an; m_cur_seg = seg[6:0];
    end
    #1;
  endtask

  task automatic test_reset();
    tick(4'b1110, 8'h06, 1'b0);
    tick(4'b1110, 8'h06, 1'b1);
    tick(4'b1110, 8'h06, 1'b1);
    checks++;
    if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== 22'h0) begin
      failures++;
      $display("FAIL reset_state dut=%h required=0", {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT});
    end
  endtask

  task automatic test_single_digit();
    logic [3:0] exp_lo;
    tick(4'hF, 8'h00, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick(4'b1110, 8'h86, 1'b0);
      exp_lo = (k >= S + 1) ? 4'h1 : 4'h0;
      checks++;
      if (DIGITS_OUT[3:0] !== exp_lo || ERR_OUT !== 1'b0) begin
        failures++;
        $display("FAIL single_latency edge=%0d dut=%h/%b required=%h/0", k, DIGITS_OUT[3:0], ERR_OUT, exp_lo);
      end
      checks++;
      if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== {m_digits, m_seen, m_frame, m_err}) begin
        failures++;
        $display("FAIL single_model edge=%0d dut=%h model=%h", k,
                 {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT}, {m_digits, m_seen, m_frame, m_err});
      end
    end
    checks++;
    if (SEEN_OUT !== 4'b0001) begin
      failures++;
      $display("FAIL single_seen dut=%b required=0001", SEEN_OUT);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ans [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] segs [4] = '{8'h77, 8'h6D, 8'h58, 8'h71};
    int frames = 0;
    bit after_frame = 0;
    tick(4'hF, 8'h00, 1'b1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        tick(ans[d], segs[d], 1'b0);
        if (after_frame) begin
          checks++;
          if (SEEN_OUT !== 4'b0000) begin
            failures++;
            $display("FAIL scan_seen_clear dut=%b required=0000", SEEN_OUT);
          end
          after_frame = 0;
        end
        if (FRAME_VALID === 1'b1) begin
          frames++;
          after_frame = 1;
          checks++;
          if (DIGITS_OUT !== 16'hFC5A) begin
            failures++;
            $display("FAIL scan_frame_digits dut=%h required=FC5A", DIGITS_OUT);
          end
        end
        checks++;
        if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== {m_digits, m_seen, m_frame, m_err}) begin
          failures++;
          $display("FAIL scan_model d=%0d c=%0d dut=%h model=%h", d, c,
                   {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT}, {m_digits, m_seen, m_frame, m_err});
        end
      end
    end
    checks++;
    if (frames != 1) begin
      failures++;
      $display("FAIL scan_frame_count dut=%0d required=1", frames);
    end
  endtask

  task automatic test_illegal();
    int errs = 0;
    tick(4'hF, 8'h00, 1'b1);
    for (int c = 0; c < 6; c++) tick(4'b1101, 8'h27, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick(4'b1101, 8'h80, 1'b0);
      if (ERR_OUT === 1'b1) errs++;
      checks++;
      if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== {m_digits, m_seen, m_frame, m_err}) begin
        failures++;
        $display("FAIL illegal_model c=%0d dut=%h model=%h", c,
                 {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT}, {m_digits, m_seen, m_frame, m_err});
      end
    end
    checks++;
    if (errs != 1 || DIGITS_OUT[7:4] !== 4'h7 || SEEN_OUT !== 4'b0010) begin
      failures++;
      $display("FAIL illegal_pulse errs=%0d nib1=%h seen=%b required 1/7/0010", errs, DIGITS_OUT[7:4], SEEN_OUT);
    end
  endtask

  task automatic test_glitch();
    tick(4'hF, 8'h00, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(4'b1110, ((c / 2) % 2) ? 8'h06 : 8'h3F, 1'b0);
      checks++;
      if (SEEN_OUT !== 4'b0000 || ERR_OUT !== 1'b0 || DIGITS_OUT !== 16'h0) begin
        failures++;
        $display("FAIL glitch_capture c=%0d seen=%b err=%b digits=%h required 0000/0/0000", c, SEEN_OUT, ERR_OUT, DIGITS_OUT);
      end
    end
    for (int c = 0; c < 6; c++) tick(4'b1110, 8'h06, 1'b0);
    checks++;
    if (DIGITS_OUT[3:0] !== 4'h1 || SEEN_OUT !== 4'b0001) begin
      failures++;
      $display("FAIL glitch_settle nib0=%h seen=%b required 1/0001", DIGITS_OUT[3:0], SEEN_OUT);
    end
  endtask

  task automatic test_multi_low();
    tick(4'hF, 8'h00, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick(4'b1100, 8'h06, 1'b0);
      checks++;
      if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== 22'h0) begin
        failures++;
        $display("FAIL multi_low c=%0d dut=%h required=0", c, {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ans [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int frames = 0;
    tick(4'hF, 8'h00, 1'b1);
    for (int c = 0; c < 6; c++) tick(4'b1110, 8'h4F, 1'b0);
    for (int c = 0; c < 6; c++) tick(4'b1101, 8'h66, 1'b0);
    checks++;
    if (SEEN_OUT !== 4'b0011 || DIGITS_OUT !== 16'h0043) begin
      failures++;
      $display("FAIL resetmid_pre seen=%b digits=%h required 0011/0043", SEEN_OUT, DIGITS_OUT);
    end
    tick(4'b1101, 8'h66, 1'b1);
    checks++;
    if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== 22'h0) begin
      failures++;
      $display("FAIL resetmid_clear dut=%h required=0", {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT});
    end
    // Interrupt a settling window, then scan digits 2,3 before 0,1.
    for (int c = 0; c < 3; c++) tick(4'b1011, 8'h5B, 1'b0);
    tick(4'b1011, 8'h5B, 1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 7; c++) begin
        tick(ans[(k + 2) % 4], GLYPH[k + 8], 1'b0);
        if (FRAME_VALID === 1'b1) frames++;
        checks++;
        if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== {m_digits, m_seen, m_frame, m_err}) begin
          failures++;
          $display("FAIL resetmid_model k=%0d c=%0d dut=%h model=%h", k, c,
                   {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT}, {m_digits, m_seen, m_frame, m_err});
        end
      end
      checks++;
      if (frames != ((k == 3) ? 1 : 0)) begin
        failures++;
        $display("FAIL resetmid_frames k=%0d dut=%0d required=%0d", k, frames, (k == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] an_pool [6] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1001};
    logic [3:0] an;
    logic [7:0] seg;
    int hold;
    tick(4'hF, 8'h00, 1'b1);
    for (int b = 0; b < 150; b++) begin
      an   = (b % 3 == 0) ? 4'($urandom) : an_pool[$urandom_range(0, 5)];
      seg  = ($urandom_range(0, 3) != 0) ? (GLYPH[$urandom_range(0, 15)] | {$urandom_range(0, 1) == 1, 7'h0})
                                         : 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        tick(an, seg, ($urandom_range(0, 99) == 0));
        checks++;
        if ({DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT} !== {m_digits, m_seen, m_frame, m_err}) begin
          failures++;
          $display("FAIL random_model b=%0d c=%0d dut=%h model=%h", b, c,
                   {DIGITS_OUT, SEEN_OUT, FRAME_VALID, ERR_OUT}, {m_digits, m_seen, m_frame, m_err});
        end
      end
    end
  endtask

  initial begin
    RESET  = 1'b1;
    AN_IN  = 4'hF;
    SEG_IN = 8'h00;
    test_reset();
    test_single_digit();
    test_scan();
    test_illegal();
    test_glitch();
    test_multi_low();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
